dm_cache_controller: RTL

Cache controller FSM for the direct-mapped, write-back, write-allocate cache between the CPU and the 1M x 16 secondary memory. It owns the 512-entry tag/valid/dirty table and a 512 x 64-bit data array, which holds four 16-bit words per line. It serves single-word CPU reads and writes and performs whole-line write-back and refill over the memory handshake.

---
 rtl/cache_definition.sv | 46 ++++
 rtl/dm_cache_controller_if.sv | 32 +++
 rtl/dm_cache_data.sv | 23 ++
 rtl/dm_cache_controller.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cache_definition.sv
// Shared types and geometry for the direct-mapped write-back cache.
package cache_definition;

  localparam int unsigned INDEX_W        = 9;
  localparam int unsigned TAG_W          = 9;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_W       = 2;
  localparam int unsigned WORD_W         = 16;
  localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int unsigned ADDR_W         = 20;
  localparam int unsigned NUM_LINES      = 1 << INDEX_W;

  localparam int unsigned TAG_MSB = 19;
  localparam int unsigned TAG_LSB = 11;
  localparam int unsigned IDX_MSB = 10;
  localparam int unsigned IDX_LSB = 2;

  typedef logic [INDEX_W-1:0]  cache_index_type;
  typedef logic [TAG_W-1:0]    cache_tag_type;
  typedef logic [LINE_W-1:0]   cache_data_type;
  typedef logic [OFFSET_W-1:0] cache_offset_type;
  typedef logic [WORD_W-1:0]   cache_word_type;

  typedef struct packed {
    logic          valid;
    logic          dirty;
    cache_tag_type tag;
  } cache_table_type;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE
  } cache_state_type;

  // Replace one 16-bit lane of a line.
  function automatic cache_data_type merge_word(cache_data_type line, cache_offset_type off,
                                                cache_word_type word);
    cache_data_type res;
    res = line;
    res[WORD_W*off +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/dm_cache_controller_if.sv
// CPU-side and memory-side handshake signals of the cache controller.
interface dm_cache_controller_if;
  import cache_definition::*;

  logic [ADDR_W-1:0] cpu_addr;
  cache_word_type    cpu_wdata;
  logic              cpu_rw;
  logic              cpu_valid;
  cache_word_type    cpu_rdata;
  logic              cpu_ready;
  logic              cpu_stopped;

  logic [ADDR_W-1:0] mem_addr;
  cache_data_type    mem_wdata;
  logic              mem_rw;
  logic              mem_valid;
  cache_data_type    mem_rdata;
  logic              mem_ready;

  // Controller view: answers the CPU, initiates memory transfers.
  modport master (
    input  cpu_addr, cpu_wdata, cpu_rw, cpu_valid, mem_rdata, mem_ready,
    output cpu_rdata, cpu_ready, cpu_stopped, mem_addr, mem_wdata, mem_rw, mem_valid
  );

  // Environment view: the CPU and the secondary memory.
  modport slave (
    output cpu_addr, cpu_wdata, cpu_rw, cpu_valid, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_ready, cpu_stopped, mem_addr, mem_wdata, mem_rw, mem_valid
  );

endinterface

// File: rtl/dm_cache_data.sv
// Line storage: 512 x 64-bit, synchronous write, combinational read.
module dm_cache_data
  import cache_definition::*;
(
  input  logic            clk_i,
  input  logic            we_i,
  input  cache_index_type index_i,
  input  cache_data_type  wdata_i,
  output cache_data_type  rdata_o
);

  cache_data_type mem_q [NUM_LINES];

  // Write the addressed line when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[index_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[index_i];

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller.
module dm_cache_controller
  import cache_definition::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  dm_cache_controller_if.master bus
);

  cache_state_type   state_q;
  logic [ADDR_W-1:0] req_addr_q;
  cache_word_type    req_wdata_q;
  logic              req_rw_q;
  cache_word_type    rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  cache_data_type    mem_wdata_q;
  logic              mem_rw_q;
  logic              mem_valid_q;
  cache_table_type   table_q [NUM_LINES];

  cache_tag_type     req_tag;
  cache_index_type   req_idx;
  cache_offset_type  req_off;
  cache_table_type   entry;
  cache_data_type    line_rd;
  cache_word_type    rd_word;
  logic              hit;
  logic              compare_hit;
  logic              mem_done;
  logic              data_we;
  cache_data_type    data_wdata;

  assign req_tag     = req_addr_q[TAG_MSB:TAG_LSB];
  assign req_idx     = req_addr_q[IDX_MSB:IDX_LSB];
  assign req_off     = req_addr_q[OFFSET_W-1:0];
  assign entry       = table_q[req_idx];
  assign hit         = entry.valid && (entry.tag == req_tag);
  assign compare_hit = (state_q == COMPARE) && hit;
  assign rd_word     = line_rd[WORD_W*req_off +: WORD_W];
  // mem_ready only counts while a request is outstanding.
  assign mem_done    = mem_valid_q && bus.mem_ready;

  // Data array write source: merged CPU word on a write hit, refill line on allocate.
  always_comb begin
    data_we    = 1'b0;
    data_wdata = line_rd;
    if (compare_hit && req_rw_q) begin
      data_we    = 1'b1;
      data_wdata = merge_word(line_rd, req_off, req_wdata_q);
    end else if ((state_q == ALLOCATE) && mem_done) begin
      data_we    = 1'b1;
      data_wdata = bus.mem_rdata;
    end
  end

  dm_cache_data u_data (
    .clk_i   (clk),
    .we_i    (data_we),
    .index_i (req_idx),
    .wdata_i (data_wdata),
    .rdata_o (line_rd)
  );

  // Controller FSM, request register, memory request registers and tag table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_rw_q    <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_valid) begin
            req_addr_q  <= bus.cpu_addr;
            req_wdata_q <= bus.cpu_wdata;
            req_rw_q    <= bus.cpu_rw;
            state_q     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (req_rw_q) begin
              table_q[req_idx] <= cache_table_type'{valid: 1'b1, dirty: 1'b1, tag: req_tag};
            end else begin
              rdata_q <= rd_word;
            end
            state_q <= IDLE;
          end else if (entry.valid && entry.dirty) begin
            mem_addr_q  <= {entry.tag, req_idx, 2'b00};
            mem_wdata_q <= line_rd;
            mem_rw_q    <= 1'b1;
            mem_valid_q <= 1'b1;
            state_q     <= WRITE_BACK;
          end else begin
            mem_addr_q  <= {req_tag, req_idx, 2'b00};
            mem_rw_q    <= 1'b0;
            mem_valid_q <= 1'b1;
            state_q     <= ALLOCATE;
          end
        end
        WRITE_BACK: begin
          // mem_valid stays high straight into the refill.
          if (mem_done) begin
            mem_addr_q <= {req_tag, req_idx, 2'b00};
            mem_rw_q   <= 1'b0;
            state_q    <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_done) begin
            table_q[req_idx] <= cache_table_type'{valid: 1'b1, dirty: 1'b0, tag: req_tag};
            mem_valid_q      <= 1'b0;
            state_q          <= COMPARE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready   = compare_hit;
  assign bus.cpu_rdata   = (compare_hit && !req_rw_q) ? rd_word : rdata_q;
  assign bus.cpu_stopped = (state_q == WRITE_BACK) || (state_q == ALLOCATE);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_rw      = mem_rw_q;
  assign bus.mem_valid   = mem_valid_q;

endmodule
